serial_adder_ha: RTL and testbench
==================================

// Module: serial_adder_ha
// PURPOSE
//  - Bit-serial WIDTH-bit adder stage built around the half-adder cell.
//  - Each cycle, two half-adder instances form one full adder. They process one bit pair, LSB first.
//  - The carry is held in a flip-flop between cycles.
//  - Consumes parallel operands from the upstream register stage with a start/done handshake.
//  - Presents the registered sum and carry-out to the downstream stage.
// PARAMETERS
//  - WIDTH  8  operand/sum width in bits; legal range 2..32.
// PORTS
//  - clk    in   1      single clock; all state updates on rising edge
//  - rst_n  in   1      reset, asynchronous, active-low
//  - start  in   1      request; sampled only in IDLE
//  - a      in   WIDTH  operand A; captured on the edge that accepts start
//  - b      in   WIDTH  operand B; captured on the edge that accepts start
//  - busy   out  1      high while in SHIFT
//  - done   out  1      one-cycle pulse; s and c are valid from this cycle
//  - s      out  WIDTH  registered sum, a+b mod 2^WIDTH
//  - c      out  1      registered carry-out (bit WIDTH of a+b)
// BEHAVIOUR
//  - Reset (rst_n=0, any time, asynchronous):
//    - state=IDLE; busy=0, done=0, s=0, c=0.
//    - Operand shift registers, result shift register, carry_q and bit counter cleared.
//  - FSM states: IDLE, SHIFT, DONE (2-bit encoding).
//  - IDLE:
//    - start=1 at edge E0 loads a_sh<=a, b_sh<=b, carry_q<=0, cnt<=0, state<=SHIFT.
//    - start=0 stays in IDLE.
//  - SHIFT, each edge:
//    - {cout,sum} = a_sh[0] + b_sh[0] + carry_q via two half-adder cells plus OR of carries.
//    - a_sh, b_sh shift right by 1; sum enters r_sh at bit WIDTH-1 while r_sh shifts right.
//    - carry_q<=cout; cnt<=cnt+1.
//  - On the SHIFT edge with cnt==WIDTH-1 (edge E_WIDTH):
//    - s<={sum,r_sh[WIDTH-1:1]}, c<=cout, state<=DONE.
//  - DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
//  - Latency:
//    - done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after start is sampled.
//    - Throughput: one operation per WIDTH+2 cycles.
//  - busy=1 exactly in cycles where state==SHIFT; done and busy are never high together.
//  - start while SHIFT or DONE is ignored: no queueing, no error flag.
//  - a/b changes after E0 have no effect on the running operation.
//  - s and c hold their last value from done until the next completion.
//    - They do not change on start acceptance or during SHIFT.
//  - Counter width is $clog2(WIDTH)+1. No wrap can occur because cnt resets on every accept.
//  - Reset mid-SHIFT aborts the operation; s/c return to 0; no done pulse is produced.
//  - start held high continuously:
//    - a new operation is accepted on the first edge in IDLE, one cycle after done.
// STRUCTURE
//  - Shared package serial_adder_pkg:
//    - state localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
//    - counter-width function.
//  - Sub-module ha_cell (a,b -> s=a^b, c=a&b), purely combinational.
//    - Instantiated twice: ha0(a_sh[0],b_sh[0]) and ha1(ha0.s,carry_q).
//    - sum=ha1.s; cout=ha0.c|ha1.c.
//  - One sequential always block with async reset for FSM + datapath.
//  - Outputs are driven directly from registers.
// TESTING (WIDTH=8)
//  - Reset, then start with a=8'h00,b=8'h00
//    -> busy for 8 cycles, done pulse, s=8'h00, c=0.
//  - a=8'hFF,b=8'h01 -> s=8'h00,c=1.
//  - a=8'hA5,b=8'h5A -> s=8'hFF,c=0.
//  - a=8'hFF,b=8'hFF -> s=8'hFE,c=1.
//  - a=8'h37,b=8'h2C; pulse start with a=8'h01,b=8'h01 at cycle 3 of SHIFT
//    -> second start ignored, result s=8'h63,c=0.
//  - Start a=8'h80,b=8'h80, drop rst_n at SHIFT cycle 4
//    -> busy=0, s=0, c=0 immediately; no done.
//    - Then release rst_n and start a=8'h80,b=8'h80 -> s=8'h00,c=1.
//  - start held high across two ops (8'h10+8'h20, then 8'h7F+8'h01)
//    -> s=8'h30 then s=8'h80; done pulses 10 cycles apart.
//  - Self-check every op against a+b using the 9-bit {c,s}.
//    - Check that busy and done are never high together.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM states and counter sizing for the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/serial_adder_ha_cell.sv
// ha_cell: combinational half adder
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder_ha.sv
// serial_adder_ha: LSB-first bit-serial adder from two half-adder cells with start/done handshake
module serial_adder_ha
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);
  localparam int CW = cnt_w(WIDTH);
  localparam int RW = WIDTH - 1;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [RW-1:0] r_sh;
  logic [CW-1:0] cnt;
  logic carry_q, s0, c0, sum, c1, cout, last;
  ha_cell ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s0), .c(c0));
  ha_cell ha1 (.a(s0), .b(carry_q), .s(sum), .c(c1));
  assign cout = c0 | c1;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    nxt = state == ST_IDLE  ? (start ? ST_SHIFT : ST_IDLE) :
          state == ST_SHIFT ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      c       <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= nxt;
      busy  <= nxt == ST_SHIFT;
      done  <= nxt == ST_DONE;
      if (state == ST_IDLE && start) begin
        a_sh    <= a;
        b_sh    <= b;
        carry_q <= 1'b0;
        cnt     <= '0;
      end else if (state == ST_SHIFT) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        r_sh    <= RW'({sum, r_sh} >> 1);
        carry_q <= cout;
        cnt     <= cnt + CW'(1);
        if (last) begin
          s <= {sum, r_sh};
          c <= cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ha.sv
// tb_serial_adder_ha: scoreboard bench comparing each completed sum with plain a+b
module tb_serial_adder_ha;
  localparam int W = 8;
  logic clk, rst_n, start, busy, done, c;
  logic [W-1:0] a, b, s;
  logic [W:0] sb[$];
  logic [W:0] e, last_res;
  int pass = 0, total = 0;

  serial_adder_ha #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .c(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) last_res = '0;
    else begin
      check("busy_done_excl", {63'd0, busy & done}, 64'd0);
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check("sum", {55'd0, c, s}, {55'd0, e});
          last_res = e;
        end
      end else if (busy) check("hold", {55'd0, c, s}, {55'd0, last_res});
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int glitch);
    int k, bc;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back({1'b0, x} + {1'b0, y});
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    k = 0;
    bc = 0;
    while (!done && k < W + 4) begin
      if (busy) bc++;
      if (k + 1 == glitch) begin
        start = 1'b1;
        a = 1;
        b = 1;
      end else start = 1'b0;
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("busy_cycles", 64'(bc), 64'(W));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, g;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_c", 64'(c), 64'd0);
    rst_n = 1'b1;
    run_op(8'h00, 8'h00, 0);
    run_op(8'hFF, 8'h01, 0);
    run_op(8'hA5, 8'h5A, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h37, 8'h2C, 3);
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_s", 64'(s), 64'd0);
    check("abort_c", 64'(c), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    run_op(8'h80, 8'h80, 0);
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    sb.push_back(9'h030);
    @(negedge clk);
    a = 8'h7F;
    b = 8'h01;
    sb.push_back(9'h080);
    k = 0;
    while (!done && k < 40) begin
      k++;
      @(negedge clk);
    end
    check("held_done1", 64'(done), 64'd1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 40);
    start = 1'b0;
    check("held_done2", 64'(done), 64'd1);
    check("held_gap", 64'(g), 64'(W + 2));
    repeat (2) @(negedge clk);
    check("held_idle", 64'(busy), 64'd0);
    repeat (40) run_op(W'($urandom), W'($urandom), int'($urandom_range(0, W)));
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
